// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite ROM and its arbiter: ROM geometry,
// ROM read latency and a helper that sizes round-robin pointers.
package sprite_pkg;

    localparam int SPRITE_ROM_DEPTH   = 72000;
    localparam int SPRITE_ROM_LATENCY = 2;
    localparam int SPRITE_ADDR_WIDTH  = $clog2(SPRITE_ROM_DEPTH);

    typedef logic [SPRITE_ADDR_WIDTH-1:0] rom_addr_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first eligible request
// found scanning upward from ptr_in, wrapping back to index 0.
module rr_picker
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [PTR_W-1:0]   ptr_in,
    input  logic [NUM_REQ-1:0] mask_in,
    output logic [NUM_REQ-1:0] grant_out
);

    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   scan_idx;
    logic               found;

    assign eligible = req_in & mask_in;

    // Scan all NUM_REQ positions starting at the pointer; first hit wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // through this block can leave a value held and infer a latch.
        grant_out = '0;
        found     = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_sum = {1'b0, ptr_in} + (PTR_W+1)'(off);
            // Explicit compare instead of a truncated mod, so non-power-of-two
            // requester counts wrap correctly.
            if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && eligible[scan_idx]) begin
                grant_out[scan_idx] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM between NUM_REQ renderers. Requester 0
// (raster) may take strict priority; the rest share round-robin. A tag
// pipeline follows each read through the ROM so the data returns to the
// requester that issued it.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = SPRITE_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 1,
    parameter int ROM_LATENCY = SPRITE_ROM_LATENCY,
    parameter bit STRICT_REQ0 = 1'b1
) (
    input  logic                          pixel_clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]            grant_out,
    output logic [ADDR_WIDTH-1:0]         rom_addr_out,
    output logic                          rom_en_out,
    input  logic [DATA_WIDTH-1:0]         rom_data_in,
    output logic [NUM_REQ-1:0]            rsp_valid_out,
    output logic [DATA_WIDTH-1:0]         rsp_data_out
);

    localparam int PTR_W     = ptr_width(NUM_REQ);
    // One stage for the registered ROM address plus one per ROM cycle.
    localparam int TAG_DEPTH = 1 + ROM_LATENCY;

    localparam logic [NUM_REQ-1:0] ALL_REQ = '1;
    // Under strict priority requester 0 never competes in the round-robin.
    localparam logic [NUM_REQ-1:0] RR_MASK =
        STRICT_REQ0 ? (ALL_REQ & ~NUM_REQ'(1)) : ALL_REQ;

    logic [PTR_W-1:0]      rr_ptr_d, rr_ptr_q;
    logic [NUM_REQ-1:0]    rr_grant;
    logic [NUM_REQ-1:0]    grant;
    logic                  strict_win;
    logic [PTR_W-1:0]      win_idx;

    logic [ADDR_WIDTH-1:0] rom_addr_d, rom_addr_q;
    logic                  rom_en_d, rom_en_q;

    logic [TAG_DEPTH-1:0]  tag_valid_d, tag_valid_q;
    logic [NUM_REQ-1:0]    tag_id_d [TAG_DEPTH];
    logic [NUM_REQ-1:0]    tag_id_q [TAG_DEPTH];

    logic [NUM_REQ-1:0]    rsp_valid_d, rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_d, rsp_data_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req_in    (req_valid_in),
        .ptr_in    (rr_ptr_q),
        .mask_in   (RR_MASK),
        .grant_out (rr_grant)
    );

    // Final grant: strict requester 0 overrides the round-robin pick; no grant in reset.
    always_comb begin
        strict_win = STRICT_REQ0 && req_valid_in[0];
        grant      = '0;
        if (!rst_in) begin
            grant = strict_win ? NUM_REQ'(1) : rr_grant;
        end
    end

    assign grant_out = grant;

    // Encode the winner and select its address; the ROM address holds when idle.
    always_comb begin
        win_idx    = '0;
        rom_addr_d = rom_addr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx    = PTR_W'(i);
                rom_addr_d = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        rom_en_d = |grant;
    end

    // Advance the pointer past a round-robin winner; strict grants leave it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rom_en_d && !strict_win) begin
            if (win_idx == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = STRICT_REQ0 ? PTR_W'(1) : '0;
            end else begin
                rr_ptr_d = win_idx + 1'b1;
            end
        end
    end

    // Shift the {valid, id} tags in step with the ROM and register the response.
    always_comb begin
        tag_valid_d[0] = rom_en_d;
        tag_id_d[0]    = grant;
        for (int s = 1; s < TAG_DEPTH; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_id_d[s]    = tag_id_q[s-1];
        end
        rsp_valid_d = tag_valid_q[TAG_DEPTH-1] ? tag_id_q[TAG_DEPTH-1] : '0;
        rsp_data_d  = tag_valid_q[TAG_DEPTH-1] ? rom_data_in : rsp_data_q;
    end

    // Control state with asynchronous clear: pointer, ROM port, tag valids, response.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of the others, independent of statement order.
        if (rst_in) begin
            rr_ptr_q    <= '0;
            rom_addr_q  <= '0;
            rom_en_q    <= 1'b0;
            tag_valid_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rom_addr_q  <= rom_addr_d;
            rom_en_q    <= rom_en_d;
            tag_valid_q <= tag_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Requester ids travelling alongside the valid bits.
    always_ff @(posedge pixel_clk_in) begin
        // NOTE: ids are left out of reset on purpose; they are ignored while
        // their valid bit is low, and the valids are cleared by reset.
        tag_id_q <= tag_id_d;
    end

    assign rom_addr_out  = rom_addr_q;
    assign rom_en_out    = rom_en_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_data_out  = rsp_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter. Three instances share one
// stimulus stream: 4 requesters with strict priority, 4 requesters pure
// round-robin, and 3 requesters pure round-robin. Each has its own ROM model
// and its own queue of expected responses.
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    localparam int AW = 17;

    typedef struct {
        int              id;
        logic [AW-1:0]   addr;
        int              due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_valid;
    logic [4*AW-1:0]   req_addr;

    logic [3:0]        grant0, grant1, rsp_v0, rsp_v1;
    logic [2:0]        grant2, rsp_v2;
    logic [AW-1:0]     rom_addr0, rom_addr1, rom_addr2;
    logic              rom_en0, rom_en1, rom_en2;
    logic              rsp_d0, rsp_d1, rsp_d2;
    logic              rom_pipe0 [3];
    logic              rom_pipe1 [3];

    exp_t              sb_q [3][$];
    int                model_ptr [3];
    bit                cur_en [3];
    logic [AW-1:0]     cur_addr [3];
    logic [AW-1:0]     last_addr [3];
    int                n_of [3]      = '{4, 4, 3};
    bit                strict_of [3] = '{1'b1, 1'b0, 1'b0};

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(1),
                         .ROM_LATENCY(2), .STRICT_REQ0(1'b1)) dut0 (
        .pixel_clk_in (clk),        .rst_in        (rst),
        .req_valid_in (req_valid),  .req_addr_in   (req_addr),
        .grant_out    (grant0),     .rom_addr_out  (rom_addr0),
        .rom_en_out   (rom_en0),    .rom_data_in   (rom_pipe1[0]),
        .rsp_valid_out(rsp_v0),     .rsp_data_out  (rsp_d0)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(1),
                         .ROM_LATENCY(2), .STRICT_REQ0(1'b0)) dut1 (
        .pixel_clk_in (clk),        .rst_in        (rst),
        .req_valid_in (req_valid),  .req_addr_in   (req_addr),
        .grant_out    (grant1),     .rom_addr_out  (rom_addr1),
        .rom_en_out   (rom_en1),    .rom_data_in   (rom_pipe1[1]),
        .rsp_valid_out(rsp_v1),     .rsp_data_out  (rsp_d1)
    );

    sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(1),
                         .ROM_LATENCY(2), .STRICT_REQ0(1'b0)) dut2 (
        .pixel_clk_in (clk),             .rst_in        (rst),
        .req_valid_in (req_valid[2:0]),  .req_addr_in   (req_addr[3*AW-1:0]),
        .grant_out    (grant2),          .rom_addr_out  (rom_addr2),
        .rom_en_out   (rom_en2),         .rom_data_in   (rom_pipe1[2]),
        .rsp_valid_out(rsp_v2),          .rsp_data_out  (rsp_d2)
    );

    // Contents of the sprite ROM: a scrambled parity of the address.
    function automatic logic rom_word(input logic [AW-1:0] a);
        logic [AW-1:0] h;
        h = a ^ (a >> 5) ^ (a << 3);
        return (^h) ^ a[1];
    endfunction

    // Winner by the arbitration rules: strict requester 0 first, otherwise
    // the first valid index at or after the pointer, modulo n.
    function automatic int pick(input logic [3:0] req, input int ptr,
                                input int n, input bit strict);
        if (strict && req[0]) return 0;
        for (int off = 0; off < n; off++) begin
            int i;
            i = (ptr + off) % n;
            if (!(strict && i == 0) && req[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Two-cycle ROM: address sampled while enabled, data two edges later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_en0) rom_pipe0[0] <= rom_word(rom_addr0);
        if (rom_en1) rom_pipe0[1] <= rom_word(rom_addr1);
        if (rom_en2) rom_pipe0[2] <= rom_word(rom_addr2);
        for (int d = 0; d < 3; d++) rom_pipe1[d] <= rom_pipe0[d];
    end

    task automatic monitor_dut(input int d, input logic [3:0] g, input logic en,
                               input logic [AW-1:0] a, input logic [3:0] rv,
                               input logic rd);
        int          w;
        logic [3:0]  exp_g;
        logic [3:0]  mask;
        logic [AW-1:0] exp_a;
        exp_t        e;
        string       tag;
        tag = $sformatf("dut%0d", d);
        if (rst) begin
            sb_q[d].delete();
            model_ptr[d] = 0;
            cur_en[d]    = 1'b0;
            cur_addr[d]  = '0;
            last_addr[d] = '0;
            check({tag, " grant_in_reset"}, 32'(g), 32'd0);
            check({tag, " rsp_in_reset"}, 32'(rv), 32'd0);
            return;
        end
        mask  = (n_of[d] == 3) ? 4'b0111 : 4'b1111;
        w     = pick(req_valid & mask, model_ptr[d], n_of[d], strict_of[d]);
        exp_g = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        check({tag, " grant"}, 32'(g), 32'(exp_g));

        exp_a = cur_en[d] ? cur_addr[d] : last_addr[d];
        check({tag, " rom_en"}, 32'(en), 32'(cur_en[d]));
        check({tag, " rom_addr"}, 32'(a), 32'(exp_a));
        last_addr[d] = exp_a;

        if (rv != 4'b0000) begin
            if (sb_q[d].size() == 0) begin
                check({tag, " rsp_unexpected"}, 32'(rv), 32'd0);
            end else begin
                e = sb_q[d].pop_front();
                check({tag, " rsp_id"}, 32'(rv), 32'(4'b0001 << e.id));
                check({tag, " rsp_data"}, 32'(rd), 32'(rom_word(e.addr)));
                check({tag, " rsp_cycle"}, 32'(cyc), 32'(e.due));
            end
        end else if (sb_q[d].size() != 0 && sb_q[d][0].due <= cyc) begin
            e = sb_q[d].pop_front();
            check({tag, " rsp_missing"}, 32'(rv), 32'(4'b0001 << e.id));
        end

        cur_en[d] = (w >= 0);
        if (w >= 0) begin
            e.id   = w;
            e.addr = req_addr[w*AW +: AW];
            e.due  = cyc + 4;
            cur_addr[d] = e.addr;
            sb_q[d].push_back(e);
            if (!(strict_of[d] && w == 0)) begin
                model_ptr[d] = (w + 1) % n_of[d];
                if (model_ptr[d] == 0 && strict_of[d]) model_ptr[d] = 1;
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        monitor_dut(0, grant0, rom_en0, rom_addr0, rsp_v0, rsp_d0);
        monitor_dut(1, grant1, rom_en1, rom_addr1, rsp_v1, rsp_d1);
        monitor_dut(2, {1'b0, grant2}, rom_en2, rom_addr2, {1'b0, rsp_v2}, rsp_d2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input int a);
        req_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic rand_addrs();
        for (int i = 0; i < 4; i++) set_addr(i, int'($urandom_range(0, SPRITE_ROM_DEPTH - 1)));
    endtask

    task automatic idle(input int n);
        req_valid = 4'b0000;
        repeat (n) tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_addr  = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Single request from requester 2.
        req_valid = 4'b0100;
        set_addr(2, 1234);
        tick();
        idle(6);

        // Everybody requesting for eight cycles.
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'b1111;
            rand_addrs();
            tick();
        end
        idle(6);

        // Requesters 0 and 2 for three cycles, then requester 0 drops.
        for (int k = 0; k < 4; k++) begin
            req_valid = (k < 3) ? 4'b0101 : 4'b0100;
            rand_addrs();
            tick();
        end
        idle(6);

        // Back-to-back reads from requester 1.
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0010;
            set_addr(1, 10 + k);
            tick();
        end
        idle(6);

        // Reset while a read from requester 3 is in flight.
        req_valid = 4'b1000;
        rand_addrs();
        tick();
        req_valid = 4'b0000;
        tick();
        rst = 1'b1;
        #1;
        check("async_reset rom_en", 32'({rom_en0, rom_en1, rom_en2}), 32'd0);
        check("async_reset rom_addr", 32'(rom_addr0 | rom_addr1 | rom_addr2), 32'd0);
        check("async_reset rsp_valid", 32'({rsp_v0, rsp_v1, rsp_v2}), 32'd0);
        check("async_reset rsp_data", 32'({rsp_d0, rsp_d1, rsp_d2}), 32'd0);
        check("async_reset grant", 32'({grant0, grant1, grant2}), 32'd0);
        tick();
        rst = 1'b0;
        idle(8);

        // Random traffic, with phases where requester 0 is held busy.
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            if (k >= 150 && k < 200) req_valid[0] = 1'b1;
            rand_addrs();
            tick();
        end
        idle(10);

        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d drained", d), 32'(sb_q[d].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port, read-only sprite ROM between NUM_REQ requesters: the live raster path plus background prefetch/overlay clients, e.g. the note-head and staff-line renderers.
- Sits between the sprite renderers and the ROM instance.
- Requester 0 (raster) optionally gets strict priority; the rest share round-robin.
- ROM read data is routed back to the winning requester after a fixed latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 17, ROM address width (covers 72000 entries).
- DATA_WIDTH, 1, ROM word width.
- ROM_LATENCY, 2, ROM address-to-douta cycles (HIGH_PERFORMANCE mode = 2).
- STRICT_REQ0, 1, 1 = requester 0 always wins when valid; 0 = all requesters round-robin.

Ports:
- pixel_clk_in  in  1  single clock.
- rst_in  in  1  asynchronous, active-high reset.
- req_valid_in  in  NUM_REQ  per-requester read request, held until granted.
- req_addr_in  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- grant_out  out  NUM_REQ  one-hot combinational grant, same cycle as the winning request.
- rom_addr_out  out  ADDR_WIDTH  registered ROM address.
- rom_en_out  out  1  registered; high in cycles where rom_addr_out carries a granted request.
- rom_data_in  in  DATA_WIDTH  ROM douta.
- rsp_valid_out  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_data_out  out  DATA_WIDTH  registered response data, valid when any rsp_valid_out bit is high.

Behaviour:
- Reset (asynchronous, active-high): rom_addr_out=0, rom_en_out=0, rsp_valid_out=0, rsp_data_out=0, rr_ptr=0, all tag-pipeline valids=0. grant_out=0 while rst_in is high.
- Arbitration, each cycle, combinational:
  - If STRICT_REQ0=1 and req_valid_in[0]=1, requester 0 wins.
  - Otherwise the winner is the first valid requester scanning upward from rr_ptr and wrapping at NUM_REQ. With STRICT_REQ0=1, index 0 is excluded from the scan.
  - No valid requests: grant_out=0.
- Throughput: one grant per cycle; the ROM never stalls. A requester may re-assert in the next cycle with a new address.
- Pointer update: on a round-robin grant to requester k, rr_ptr <= (k+1) mod NUM_REQ. If that result is 0 and STRICT_REQ0=1, it skips to 1. A strict grant to requester 0 leaves rr_ptr unchanged.
- Cycle t = grant cycle:
  - rom_addr_out and rom_en_out update at the edge ending t.
  - The ROM samples rom_addr_out during t+1; rom_data_in is valid in cycle t+1+ROM_LATENCY.
  - The response is registered: rsp_valid_out[k] and rsp_data_out are high/valid in cycle t+2+ROM_LATENCY (t+4 with defaults).
- Tag pipeline: a shift register of depth 1+ROM_LATENCY carrying {valid, one-hot id}, aligned with the data.
- When rom_en_out=0, rom_addr_out holds its previous value.
- rsp_data_out holds its last value when no response is valid.
- Boundaries:
  - All requesters valid continuously with STRICT_REQ0=0: grants cycle 0,1,2,3,0,...
  - Requester 0 held high with STRICT_REQ0=1: requesters 1..NUM_REQ-1 are starved. This is intended; the raster path must leave gaps in blanking.
  - A request dropped before it is granted is lost silently, with no response.
  - Reset mid-flight clears the tag pipeline; in-flight responses are never emitted.
  - NUM_REQ not a power of two: the wrap uses an explicit compare, not a truncated mod.

Decomposition:
- Shared package sprite_pkg holds:
  - typedef rom_addr_t (logic [ADDR_WIDTH-1:0]);
  - constant SPRITE_ROM_LATENCY=2;
  - constant SPRITE_ROM_DEPTH=72000.
- One sub-module: rr_picker (combinational; inputs are the request vector, pointer and mask; output is a one-hot winner). The tag pipeline stays inline.

Test Plan:
- Reset, then single request: req_valid_in=4'b0100, addr[2]=17'd1234 in cycle 0 -> grant_out=4'b0100 in cycle 0, rom_addr_out=1234 with rom_en_out=1 in cycle 1, rsp_valid_out=4'b0100 with ROM word 1234 in cycle 4.
- STRICT_REQ0=0, all four held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses arrive in the same order 4 cycles later, with the correct data per address.
- STRICT_REQ0=1, requesters 0 and 2 valid for 3 cycles, then requester 0 drops -> grants 0,0,0,2; rr_ptr becomes 3.
- Back-to-back: requester 1 issues addrs 10,11,12 in consecutive cycles -> rsp_valid_out[1] high for 3 consecutive cycles carrying ROM[10], ROM[11], ROM[12].
- Reset mid-flight: grant requester 3 at cycle 0, assert rst_in at cycle 2 for 1 cycle -> no rsp_valid_out pulse, all outputs 0 asynchronously.
- NUM_REQ=3, STRICT_REQ0=0, all valid -> grant sequence 0,1,2,0; never an all-zero grant while any request is valid.
